// File: rtl/chunk_row_looper_pkg.sv
// -----------------------------------------------------------------------------
// chunk_row_looper_pkg
//   Shared configuration for the chunk row looper: memory dimensionality,
//   number of input configurations, datapath widths, the FSM state type and
//   small helpers used by the looper and its row counter.
//
//   Optional feature macro used by the looper: CHUNK_ROW_CLIP_EN
//   (clip rows against i_mbound; undefined = no clipping).
// -----------------------------------------------------------------------------
package chunk_row_looper_pkg;

    localparam int DIM            = 3;   // dim DIM-1 is innermost/contiguous
    localparam int N_ICFG         = 2;
    localparam int WORK_BW        = 16;
    localparam int GLOBAL_ADDR_BW = 32;

    localparam int WBW     = WORK_BW;
    localparam int GBW     = GLOBAL_ADDR_BW;
    localparam int ICFG_BW = $clog2(N_ICFG + 1);
    localparam int NDIG    = DIM - 1;    // counted (outer) dimensions

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A zero extent means "one element" along that dimension.
    function automatic logic [WBW-1:0] shape_eff(input logic [WBW-1:0] s);
        return (s == '0) ? WBW'(1) : s;
    endfunction

    // Offsets are two's complement; widen them to address width.
    function automatic logic [GBW-1:0] sext(input logic [WBW-1:0] v);
        return {{(GBW-WBW){v[WBW-1]}}, v};
    endfunction

endpackage

// File: rtl/chunk_row_looper_nd_row_counter.sv
// -----------------------------------------------------------------------------
// nd_row_counter
//   Mixed-radix counter with NDIG digits. Digit NDIG-1 is the fastest, digit 0
//   the slowest. Each digit wraps to 0 after reaching its limit and carries
//   into the next-outer digit.
//
//   Ports
//     i_clk, i_rst    clock, asynchronous active-high reset
//     i_clear         force all digits to 0 next cycle (has priority)
//     i_advance       step the counter by one row
//     i_limit         per-digit last value (extent-1), digit d at [d*WBW +: WBW]
//     o_cnt_nxt       next-cycle counter value (same packing as i_limit)
//     o_islast_nxt    next-cycle value has every digit at its limit
//     o_carry         advancing from the final combination (wraps to all 0)
// -----------------------------------------------------------------------------
module nd_row_counter
    import chunk_row_looper_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [NDIG*WBW-1:0]  i_limit,
    output logic [NDIG*WBW-1:0]  o_cnt_nxt,
    output logic                 o_islast_nxt,
    output logic                 o_carry
);

    logic [NDIG-1:0][WBW-1:0] lim;
    logic [NDIG-1:0][WBW-1:0] cnt_q;
    logic [NDIG-1:0][WBW-1:0] cnt_d;
    logic                     at_limit;
    logic                     ripple;

    assign lim = i_limit;

    always_comb begin
        at_limit = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (cnt_q[d] != lim[d]) at_limit = 1'b0;
        end
    end

    // Ripple increment from the fastest digit outward.
    always_comb begin
        cnt_d  = cnt_q;
        ripple = 1'b1;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_advance) begin
            for (int d = NDIG - 1; d >= 0; d--) begin
                if (ripple) begin
                    if (cnt_q[d] >= lim[d]) begin
                        cnt_d[d] = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + WBW'(1);
                        ripple   = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        o_islast_nxt = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (cnt_d[d] != lim[d]) o_islast_nxt = 1'b0;
        end
    end

    assign o_cnt_nxt = cnt_d;
    assign o_carry   = i_advance && at_limit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chunk_row_looper.sv
// -----------------------------------------------------------------------------
// chunk_row_looper
//   Takes one chunk origin (offset per dim + config id) per input handshake and
//   emits one row request (global start address, burst length) per output
//   handshake, walking every combination of the outer dims. The innermost
//   extent is the burst length.
//
//   Optional feature: define CHUNK_ROW_CLIP_EN to clip rows against i_mbound
//   (outer coordinate out of range -> len 0; inner span clipped to [0,bound)).
//   Default build ignores i_mbound.
//
//   Handshake: a transfer happens in a cycle with rdy && ack; rdy never
//   depends combinationally on ack, ack may depend on rdy.
//
//   Ports
//     i_clk, i_rst      clock, asynchronous active-high reset
//     i_mofs_rdy/ack    chunk origin handshake
//     i_mofs            per-dim signed origin, dim d at [d*WBW +: WBW]
//     i_id              config index
//     i_mlinear         base address per config, cfg c at [c*GBW +: GBW]
//     i_mstride         stride, (cfg c, dim d) at [(c*DIM+d)*GBW +: GBW]
//     i_mshape          extent, (cfg c, dim d) at [(c*DIM+d)*WBW +: WBW]
//     i_mbound          array size, same packing as i_mshape
//     o_row_rdy/ack     row request handshake
//     o_addr, o_len     row start address, row length in elements
//     o_id, o_islast    config id of the chunk, final row of the chunk
// -----------------------------------------------------------------------------
module chunk_row_looper
    import chunk_row_looper_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mofs_rdy,
    output logic                        i_mofs_ack,
    input  logic [DIM*WBW-1:0]          i_mofs,
    input  logic [ICFG_BW-1:0]          i_id,
    input  logic [N_ICFG*GBW-1:0]       i_mlinear,
    input  logic [N_ICFG*DIM*GBW-1:0]   i_mstride,
    input  logic [N_ICFG*DIM*WBW-1:0]   i_mshape,
    input  logic [N_ICFG*DIM*WBW-1:0]   i_mbound,
    output logic                        o_row_rdy,
    input  logic                        o_row_ack,
    output logic [GBW-1:0]              o_addr,
    output logic [WBW-1:0]              o_len,
    output logic [ICFG_BW-1:0]          o_id,
    output logic                        o_islast
);

    state_e                   state_q, state_d;
    logic [DIM-1:0][WBW-1:0]  mofs_q, mofs_d;
    logic [ICFG_BW-1:0]       id_q, id_d;
    logic                     row_rdy_q, row_rdy_d;
    logic [GBW-1:0]           addr_q, addr_d;
    logic [WBW-1:0]           len_q, len_d;
    logic [ICFG_BW-1:0]       oid_q, oid_d;
    logic                     islast_q, islast_d;

    logic                     mofs_ack;
    logic                     row_fire;

    // Config selected by the id that will be current next cycle.
    logic [GBW-1:0]           lin_sel;
    logic [DIM-1:0][GBW-1:0]  stride_sel;
    logic [DIM-1:0][WBW-1:0]  shape_sel;
`ifdef CHUNK_ROW_CLIP_EN
    logic [DIM-1:0][WBW-1:0]  bound_sel;
`else
    logic                     mbound_unused;
`endif

    logic [NDIG-1:0][WBW-1:0] lim;
    logic [NDIG-1:0][WBW-1:0] cnt_nxt;
    logic                     islast_nxt;
    logic                     chunk_done;

    logic [GBW-1:0]           coord_v;
    logic [GBW-1:0]           acc_v;
    logic [GBW-1:0]           lo_v;
    logic [GBW-1:0]           clo_v;
    logic [WBW-1:0]           len_full;
    logic [WBW-1:0]           len_calc;
    logic [GBW-1:0]           addr_calc;
`ifdef CHUNK_ROW_CLIP_EN
    logic [GBW-1:0]           hi_v;
    logic [GBW-1:0]           chi_v;
    logic                     oob_v;
`endif

    // ---------------------------------------------------------------- handshake
    assign row_fire = row_rdy_q && o_row_ack;

    // In RUN a new chunk is taken only as the last row leaves, so chunks
    // follow each other without a bubble.
    always_comb begin
        if (state_q == IDLE) begin
            mofs_ack = i_mofs_rdy;
        end else begin
            mofs_ack = i_mofs_rdy && o_row_ack && islast_q;
        end
    end

    assign i_mofs_ack = mofs_ack;

    always_comb begin
        state_d = state_q;
        mofs_d  = mofs_q;
        id_d    = id_q;
        if (mofs_ack) begin
            state_d = RUN;
            mofs_d  = i_mofs;
            id_d    = i_id;
        end else if (chunk_done) begin
            state_d = IDLE;
        end
    end

    // ---------------------------------------------------------------- config mux
    always_comb begin
        lin_sel    = '0;
        stride_sel = '0;
        shape_sel  = '0;
`ifdef CHUNK_ROW_CLIP_EN
        bound_sel  = '0;
`endif
        for (int c = 0; c < N_ICFG; c++) begin
            if (id_d == ICFG_BW'(c)) begin
                lin_sel = i_mlinear[c*GBW +: GBW];
                for (int d = 0; d < DIM; d++) begin
                    stride_sel[d] = i_mstride[(c*DIM+d)*GBW +: GBW];
                    shape_sel[d]  = i_mshape[(c*DIM+d)*WBW +: WBW];
`ifdef CHUNK_ROW_CLIP_EN
                    bound_sel[d]  = i_mbound[(c*DIM+d)*WBW +: WBW];
`endif
                end
            end
        end
    end

`ifndef CHUNK_ROW_CLIP_EN
    assign mbound_unused = ^i_mbound;
`endif

    always_comb begin
        for (int d = 0; d < NDIG; d++) begin
            lim[d] = shape_eff(shape_sel[d]) - WBW'(1);
        end
    end

    // ---------------------------------------------------------------- counter
    nd_row_counter u_cnt (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (mofs_ack),
        .i_advance    (row_fire),
        .i_limit      (lim),
        .o_cnt_nxt    (cnt_nxt),
        .o_islast_nxt (islast_nxt),
        .o_carry      (chunk_done)
    );

    // ---------------------------------------------------------------- address
    // Address of the row the counter will hold next cycle; all arithmetic
    // wraps mod 2^GBW, so signed offsets just need sign extension.
    always_comb begin
        acc_v   = lin_sel;
        coord_v = '0;
`ifdef CHUNK_ROW_CLIP_EN
        oob_v   = 1'b0;
`endif
        for (int d = 0; d < NDIG; d++) begin
            coord_v = sext(mofs_d[d]) + GBW'(cnt_nxt[d]);
            acc_v   = acc_v + coord_v * stride_sel[d];
`ifdef CHUNK_ROW_CLIP_EN
            if ($signed(coord_v) < 0 ||
                $signed(coord_v) >= $signed(GBW'(bound_sel[d]))) begin
                oob_v = 1'b1;
            end
`endif
        end

        len_full = shape_eff(shape_sel[DIM-1]);
        lo_v     = sext(mofs_d[DIM-1]);
`ifdef CHUNK_ROW_CLIP_EN
        // Clip [lo, lo+len) to [0, bound); an out-of-range outer coordinate
        // still produces a row so the row count stays fixed.
        hi_v  = lo_v + GBW'(len_full);
        clo_v = ($signed(lo_v) < 0) ? '0 : lo_v;
        chi_v = ($signed(hi_v) > $signed(GBW'(bound_sel[DIM-1])))
                ? GBW'(bound_sel[DIM-1]) : hi_v;
        if (!oob_v && ($signed(chi_v) > $signed(clo_v))) begin
            len_calc = WBW'(chi_v - clo_v);
        end else begin
            len_calc = '0;
        end
`else
        clo_v    = lo_v;
        len_calc = len_full;
`endif
        addr_calc = acc_v + clo_v * stride_sel[DIM-1];
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        row_rdy_d = 1'b0;
        addr_d    = addr_q;
        len_d     = len_q;
        oid_d     = oid_q;
        islast_d  = islast_q;
        if (state_d == RUN) begin
            row_rdy_d = 1'b1;
            addr_d    = addr_calc;
            len_d     = len_calc;
            oid_d     = id_d;
            islast_d  = islast_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            mofs_q    <= '0;
            id_q      <= '0;
            row_rdy_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            oid_q     <= '0;
            islast_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mofs_q    <= mofs_d;
            id_q      <= id_d;
            row_rdy_q <= row_rdy_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            oid_q     <= oid_d;
            islast_q  <= islast_d;
        end
    end

    assign o_row_rdy = row_rdy_q;
    assign o_addr    = addr_q;
    assign o_len     = len_q;
    assign o_id      = oid_q;
    assign o_islast  = islast_q;

endmodule

// File: tb/tb_chunk_row_looper.sv
// -----------------------------------------------------------------------------
// tb_chunk_row_looper
//   Bench for chunk_row_looper: directed chunk table, hand-written corner
//   sequences (back-to-back, mid-chunk reset, degenerate shape, clipping when
//   CHUNK_ROW_CLIP_EN is defined) and randomized chunks with random ack, all
//   checked against a row-list model built from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_chunk_row_looper;
    import chunk_row_looper_pkg::*;

    localparam int EW = GBW + WBW + ICFG_BW + 1;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       i_rst;
    logic                       i_mofs_rdy;
    logic                       i_mofs_ack;
    logic [DIM*WBW-1:0]         i_mofs;
    logic [ICFG_BW-1:0]         i_id;
    logic [N_ICFG*GBW-1:0]      i_mlinear;
    logic [N_ICFG*DIM*GBW-1:0]  i_mstride;
    logic [N_ICFG*DIM*WBW-1:0]  i_mshape;
    logic [N_ICFG*DIM*WBW-1:0]  i_mbound;
    logic                       o_row_rdy;
    logic                       o_row_ack;
    logic [GBW-1:0]             o_addr;
    logic [WBW-1:0]             o_len;
    logic [ICFG_BW-1:0]         o_id;
    logic                       o_islast;

    chunk_row_looper dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_mofs_rdy (i_mofs_rdy),
        .i_mofs_ack (i_mofs_ack),
        .i_mofs     (i_mofs),
        .i_id       (i_id),
        .i_mlinear  (i_mlinear),
        .i_mstride  (i_mstride),
        .i_mshape   (i_mshape),
        .i_mbound   (i_mbound),
        .o_row_rdy  (o_row_rdy),
        .o_row_ack  (o_row_ack),
        .o_addr     (o_addr),
        .o_len      (o_len),
        .o_id       (o_id),
        .o_islast   (o_islast)
    );

    // ------------------------------------------------------------ bench state
    int n_cmp = 0;
    int n_err = 0;
    int fired = 0;
    int ack_mode = 0;   // 0: always 1, 1: toggle, 2: random

    logic [EW-1:0]  exp_q[$];
    logic [GBW-1:0] log_addr[$];
    logic [WBW-1:0] log_len[$];

    longint cfg_lin[N_ICFG];
    int     cfg_stride[N_ICFG][DIM];
    int     cfg_shape[N_ICFG][DIM];
    int     cfg_bound[N_ICFG][DIM];

    typedef struct {
        int     id;
        int     m0;
        int     m1;
        int     m2;
        int     rows;
        longint first_addr;
        longint last_addr;
        int     len;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int c = 0; c < N_ICFG; c++) begin
            i_mlinear[c*GBW +: GBW] = cfg_lin[c][GBW-1:0];
            for (int d = 0; d < DIM; d++) begin
                i_mstride[(c*DIM+d)*GBW +: GBW] = GBW'(cfg_stride[c][d]);
                i_mshape[(c*DIM+d)*WBW +: WBW]  = WBW'(cfg_shape[c][d]);
                i_mbound[(c*DIM+d)*WBW +: WBW]  = WBW'(cfg_bound[c][d]);
            end
        end
    endtask

    task automatic set_cfg(input int c, input longint lin,
                           input int st0, input int st1, input int st2,
                           input int sh0, input int sh1, input int sh2,
                           input int b0, input int b1, input int b2);
        cfg_lin[c] = lin;
        cfg_stride[c][0] = st0; cfg_stride[c][1] = st1; cfg_stride[c][2] = st2;
        cfg_shape[c][0]  = sh0; cfg_shape[c][1]  = sh1; cfg_shape[c][2]  = sh2;
        cfg_bound[c][0]  = b0;  cfg_bound[c][1]  = b1;  cfg_bound[c][2]  = b2;
        apply_cfg();
    endtask

    // ------------------------------------------------------------ model
    // Row r of a chunk: decompose r in mixed radix over the outer extents
    // (last outer dim fastest), then apply the address/clip rules directly.
    task automatic model_push(input int id, input int m0, input int m1, input int m2);
        int s[DIM];
        int mo[DIM];
        int c[DIM];
        int rows;
        int rem;
        int len;
        int lo;
        longint a;
`ifdef CHUNK_ROW_CLIP_EN
        int hi;
        bit oob;
`endif
        mo[0] = m0; mo[1] = m1; mo[2] = m2;
        rows = 1;
        for (int d = 0; d < DIM; d++) begin
            s[d] = (cfg_shape[id][d] == 0) ? 1 : cfg_shape[id][d];
            if (d < DIM - 1) rows = rows * s[d];
        end
        for (int r = 0; r < rows; r++) begin
            rem = r;
            c[DIM-1] = 0;
            for (int d = DIM - 2; d >= 0; d--) begin
                c[d] = mo[d] + rem % s[d];
                rem  = rem / s[d];
            end
            lo  = mo[DIM-1];
            len = s[DIM-1];
`ifdef CHUNK_ROW_CLIP_EN
            hi  = lo + s[DIM-1];
            oob = 1'b0;
            for (int d = 0; d < DIM - 1; d++) begin
                if (c[d] < 0 || c[d] >= cfg_bound[id][d]) oob = 1'b1;
            end
            if (lo < 0) lo = 0;
            if (hi > cfg_bound[id][DIM-1]) hi = cfg_bound[id][DIM-1];
            len = (!oob && hi > lo) ? hi - lo : 0;
`endif
            a = cfg_lin[id];
            for (int d = 0; d < DIM - 1; d++) a = a + longint'(c[d]) * cfg_stride[id][d];
            a = a + longint'(lo) * cfg_stride[id][DIM-1];
            exp_q.push_back({a[GBW-1:0], WBW'(len), ICFG_BW'(id), (r == rows - 1)});
        end
    endtask

    // ------------------------------------------------------------ ack driver
    initial begin
        o_row_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       o_row_ack = 1'b1;
                1:       o_row_ack = ~o_row_ack;
                default: o_row_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ------------------------------------------------------------ scoreboard
    // Every cycle a row is offered it must equal the oldest expected row,
    // which also covers holding steady while stalled.
    initial begin
        logic [EW-1:0] act;
        forever begin
            @(negedge clk);
            if (!i_rst && o_row_rdy) begin
                act = {o_addr, o_len, o_id, o_islast};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL row_unexpected: got addr=%0d len=%0d id=%0d last=%0d, expected no row",
                             o_addr, o_len, o_id, o_islast);
                end else if (act !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL row: got addr=%0d len=%0d id=%0d last=%0d, expected addr=%0d len=%0d id=%0d last=%0d",
                             o_addr, o_len, o_id, o_islast,
                             exp_q[0][EW-1 -: GBW], exp_q[0][WBW+ICFG_BW : ICFG_BW+1],
                             exp_q[0][ICFG_BW:1], exp_q[0][0]);
                end
                if (o_row_ack) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    log_addr.push_back(o_addr);
                    log_len.push_back(o_len);
                    fired++;
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic send_chunk(input int id, input int m0, input int m1, input int m2,
                              output bit b2b);
        bit done;
        done = 1'b0;
        b2b  = 1'b0;
        @(posedge clk);
        #2;
        i_mofs_rdy = 1'b1;
        i_mofs     = {WBW'(m2), WBW'(m1), WBW'(m0)};
        i_id       = ICFG_BW'(id);
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (i_mofs_ack) begin
                done = 1'b1;
                b2b  = o_row_rdy && o_row_ack && o_islast;
                model_push(id, m0, m1, m2);
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL mofs_accept: got no i_mofs_ack in 400 cycles, expected accept");
        end
        @(posedge clk);
        #2;
        i_mofs_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 600 && !idle; t++) begin
            @(negedge clk);
            if (!o_row_rdy && exp_q.size() == 0) idle = 1'b1;
        end
        if (!idle) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: got rdy=%0d pending=%0d, expected idle", o_row_rdy, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ main
    initial begin
        int base;
        bit b2b;
        int nz;

        vecs[0] = '{0, 1, 2, 4, 6, 1100, 1196, 8};
        vecs[1] = '{0, 0, 0, 0, 6, 1000, 1096, 8};
        vecs[2] = '{0, 3, 0, 7, 6, 1199, 1295, 8};
        vecs[3] = '{1, 0, 0, 0, 1, 0, 0, 4};
        vecs[4] = '{1, 2, 1, 5, 1, 77, 77, 4};

        i_rst      = 1'b1;
        i_mofs_rdy = 1'b0;
        i_mofs     = '0;
        i_id       = '0;
        i_mlinear  = '0;
        i_mstride  = '0;
        i_mshape   = '0;
        i_mbound   = '0;
        set_cfg(0, 1000, 64, 16, 1, 2, 3, 8, 100, 100, 100);
        set_cfg(1, 0,    32,  8, 1, 1, 1, 4, 100, 100, 100);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy",    o_row_rdy,  0);
        check("reset_addr",   o_addr,     0);
        check("reset_len",    o_len,      0);
        check("reset_id",     o_id,       0);
        check("reset_islast", o_islast,   0);
        check("reset_ack",    i_mofs_ack, 0);
        @(posedge clk);
        #3;
        i_rst = 1'b0;

        // Directed table: pass 0 with ack held high, pass 1 with ack toggling.
        for (int pass = 0; pass < 2; pass++) begin
            ack_mode = pass;
            for (int v = 0; v < 5; v++) begin
                base = fired;
                send_chunk(vecs[v].id, vecs[v].m0, vecs[v].m1, vecs[v].m2, b2b);
                @(negedge clk);
                check($sformatf("v%0d_p%0d_latency", v, pass), o_row_rdy, 1);
                wait_idle();
                check($sformatf("v%0d_p%0d_rows", v, pass), fired - base, vecs[v].rows);
                if (fired - base == vecs[v].rows) begin
                    check($sformatf("v%0d_p%0d_first", v, pass), log_addr[base], vecs[v].first_addr);
                    check($sformatf("v%0d_p%0d_last", v, pass), log_addr[fired-1], vecs[v].last_addr);
                    check($sformatf("v%0d_p%0d_len", v, pass), log_len[base], vecs[v].len);
                end
            end
        end

        // Back-to-back: second chunk taken as the first chunk's last row leaves.
        ack_mode = 0;
        send_chunk(0, 1, 2, 4, b2b);
        send_chunk(1, 0, 0, 0, b2b);
        check("b2b_same_cycle", b2b, 1);
        @(negedge clk);
        check("b2b_rdy",    o_row_rdy, 1);
        check("b2b_addr",   o_addr,    0);
        check("b2b_len",    o_len,     4);
        check("b2b_islast", o_islast,  1);
        check("b2b_id",     o_id,      1);
        wait_idle();

        // Reset mid-chunk after the third row.
        base = fired;
        send_chunk(0, 1, 2, 4, b2b);
        for (int t = 0; t < 100 && fired < base + 3; t++) @(negedge clk);
        check("rst_mid_rows_seen", (fired >= base + 3) ? 1 : 0, 1);
        @(posedge clk);
        #3;
        i_rst = 1'b1;
        #1;
        check("rst_mid_rdy",    o_row_rdy, 0);
        check("rst_mid_addr",   o_addr,    0);
        check("rst_mid_len",    o_len,     0);
        check("rst_mid_id",     o_id,      0);
        check("rst_mid_islast", o_islast,  0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        i_rst = 1'b0;
        base = fired;
        send_chunk(0, 1, 2, 4, b2b);
        wait_idle();
        check("rst_after_rows", fired - base, 6);
        if (fired - base == 6) check("rst_after_first", log_addr[base], 1100);

        // Degenerate outer shape: exactly one row.
        set_cfg(1, 0, 32, 8, 1, 0, 0, 5, 100, 100, 100);
        ack_mode = 1;
        base = fired;
        send_chunk(1, 1, 1, 0, b2b);
        wait_idle();
        check("degen_rows", fired - base, 1);
        if (fired - base == 1) begin
            check("degen_addr", log_addr[base], 40);
            check("degen_len",  log_len[base],  5);
        end

`ifdef CHUNK_ROW_CLIP_EN
        // Clipping: only coordinate (1,2) is in range; its span 6..13 clips to 6..9.
        set_cfg(0, 1000, 64, 16, 1, 2, 3, 8, 2, 3, 10);
        ack_mode = 0;
        base = fired;
        send_chunk(0, 1, 2, 6, b2b);
        wait_idle();
        check("clip_rows", fired - base, 6);
        nz = 0;
        for (int i = base; i < fired; i++) if (log_len[i] != 0) nz++;
        check("clip_nonzero_rows", nz, 1);
        if (fired - base == 6) begin
            check("clip_first_len",  log_len[base],  4);
            check("clip_first_addr", log_addr[base], 1102);
        end
`else
        nz = 0;
`endif

        // Randomized chunks and configs with random ack.
        ack_mode = 2;
        for (int g = 0; g < 14; g++) begin
            wait_idle();
            for (int c = 0; c < N_ICFG; c++) begin
                set_cfg(c, longint'($urandom()),
                        int'($urandom_range(0, 500)), int'($urandom_range(0, 500)),
                        int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 10)));
            end
            for (int k = 0; k < 3; k++) begin
                send_chunk(int'($urandom_range(0, N_ICFG - 1)),
                           int'($urandom_range(0, 9)) - 3,
                           int'($urandom_range(0, 9)) - 3,
                           int'($urandom_range(0, 9)) - 3, b2b);
            end
        end
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
